// File: rtl/dmem_sram_bridge_pkg.sv
// Shared memory-access codes and data-side bridge state encodings.
// The instruction-side bridge reuses dm_state_t.
package dmem_sram_bridge_pkg;

    localparam logic [1:0] MEM_BYTE     = 2'b00;
    localparam logic [1:0] MEM_HALFWORD = 2'b01;
    localparam logic [1:0] MEM_WORD     = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_ADDR = 2'd1,
        DM_DATA = 2'd2,
        DM_DONE = 2'd3
    } dm_state_t;

    function automatic logic mem_code_ok(input logic [1:0] membyte);
        return (membyte == MEM_BYTE) || (membyte == MEM_HALFWORD) || (membyte == MEM_WORD);
    endfunction

    // Unknown size codes fall back to a word access.
    function automatic logic [1:0] mem_to_size(input logic [1:0] membyte);
        case (membyte)
            MEM_BYTE:     return SIZE_BYTE;
            MEM_HALFWORD: return SIZE_HALF;
            default:      return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// SRAM-like data bus: one request phase (req/addr_ok), one data phase (data_ok).
interface dmem_sram_bridge_if #(
    parameter int ADDR_W = 32
) ();

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/dmem_sram_bridge.sv
// Memory-stage bridge from mem_ctrl to an SRAM-like bus: one transaction per
// memory instruction, stall while outstanding, result held until the pipe advances.
//
// state   | meaning
// DM_IDLE | no transaction; accepts a new memenM
// DM_ADDR | data_req high, waiting for addr_ok
// DM_DATA | waiting for data_ok
// DM_DONE | result held while the pipeline is stalled elsewhere
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              memenM,
    input  logic [3:0]        memwenM,
    input  logic [1:0]        membyteM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [31:0]       realwdataM,
    input  logic              flushM,
    input  logic              stallallM,
    output logic [31:0]       readdataM,
    output logic              d_stall,
    dmem_sram_bridge_if.master bus
);

    dm_state_t         state;
    logic              req_r;
    logic              wr_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              cancel_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DM_IDLE;
            req_r    <= 1'b0;
            wr_r     <= 1'b0;
            size_r   <= '0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
            cancel_r <= 1'b0;
        end else begin
            case (state)
                DM_IDLE: begin
                    if (memenM && !flushM) begin
                        wr_r     <= (|memwenM) && mem_code_ok(membyteM);
                        size_r   <= mem_to_size(membyteM);
                        addr_r   <= addrM;
                        wdata_r  <= realwdataM;
                        req_r    <= 1'b1;
                        cancel_r <= 1'b0;
                        state    <= DM_ADDR;
                    end
                end
                DM_ADDR: begin
                    if (flushM)
                        cancel_r <= 1'b1;
                    if (bus.data_addr_ok) begin
                        req_r <= 1'b0;
                        state <= DM_DATA;
                    end
                end
                DM_DATA: begin
                    if (bus.data_data_ok) begin
                        rdata_r  <= bus.data_rdata;
                        cancel_r <= 1'b0;
                        // A cancelled instruction never waits in DONE for a pipe that dropped it.
                        state    <= (stallallM && !cancel_r && !flushM) ? DM_DONE : DM_IDLE;
                    end else if (flushM) begin
                        cancel_r <= 1'b1;
                    end
                end
                DM_DONE: begin
                    if (!stallallM)
                        state <= DM_IDLE;
                end
                default: state <= DM_IDLE;
            endcase
        end
    end

    assign bus.data_req   = req_r;
    assign bus.data_wr    = wr_r;
    assign bus.data_size  = size_r;
    assign bus.data_addr  = addr_r;
    assign bus.data_wdata = wdata_r;

    assign d_stall = ((state == DM_IDLE) && memenM && !flushM) ||
                     (state == DM_ADDR) ||
                     ((state == DM_DATA) && !bus.data_data_ok);

    assign readdataM = ((state == DM_DATA) && bus.data_data_ok) ? bus.data_rdata : rdata_r;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Bench for dmem_sram_bridge: scripted SRAM slave, directed cases then randomized accesses.
module tb_dmem_sram_bridge;
    import dmem_sram_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        memenM;
    logic [3:0]  memwenM;
    logic [1:0]  membyteM;
    logic [31:0] addrM;
    logic [31:0] realwdataM;
    logic        flushM;
    logic        stallallM;
    logic [31:0] readdataM;
    logic        d_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rdata;

    dmem_sram_bridge_if #(.ADDR_W(32)) bus ();

    dmem_sram_bridge #(.ADDR_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .memenM     (memenM),
        .memwenM    (memwenM),
        .membyteM   (membyteM),
        .addrM      (addrM),
        .realwdataM (realwdataM),
        .flushM     (flushM),
        .stallallM  (stallallM),
        .readdataM  (readdataM),
        .d_stall    (d_stall),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One memory instruction from IDLE: alat/dlat are cycles until addr_ok/data_ok,
    // hold is the number of DONE cycles, flush pulses flushM in the first ADDR cycle.
    task automatic access(input logic [3:0] wen, input logic [1:0] code, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd, input int alat,
                          input int dlat, input int hold, input bit flush);
        logic       exp_wr;
        logic [1:0] exp_sz;
        exp_wr = (wen != 4'd0) && (code != 2'b11);
        exp_sz = (code == 2'b11) ? 2'd2 : code;

        memenM = 1'b1; memwenM = wen; membyteM = code; addrM = addr; realwdataM = wdata;
        flushM = 1'b0; stallallM = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        #1;
        chk("idle_stall", d_stall, 1);
        chk("idle_req", bus.data_req, 0);
        chk("idle_rdata", readdataM, last_rdata);
        @(negedge clk);

        // Pipeline inputs change freely once the request is captured.
        addrM = $urandom; realwdataM = $urandom; memwenM = 4'($urandom); membyteM = 2'($urandom);
        for (int i = 1; i <= alat; i++) begin
            flushM = flush && (i == 1);
            bus.data_addr_ok = (i == alat);
            bus.data_data_ok = (i == alat) ? 1'b0 : 1'($urandom);
            bus.data_rdata   = $urandom;
            #1;
            chk("addr_req", bus.data_req, 1);
            chk("addr_stall", d_stall, 1);
            chk("addr_wr", bus.data_wr, exp_wr);
            chk("addr_size", bus.data_size, exp_sz);
            chk("addr_addr", bus.data_addr, addr);
            chk("addr_wdata", bus.data_wdata, wdata);
            chk("addr_rdata", readdataM, last_rdata);
            @(negedge clk);
        end
        flushM = 1'b0; bus.data_addr_ok = 1'b0;

        for (int i = 1; i <= dlat; i++) begin
            bus.data_data_ok = (i == dlat);
            bus.data_rdata   = (i == dlat) ? rd : $urandom;
            stallallM        = (i == dlat) ? (hold > 0) : 1'($urandom);
            #1;
            chk("data_req", bus.data_req, 0);
            chk("data_stall", d_stall, (i == dlat) ? 1'b0 : 1'b1);
            chk("data_rdata", readdataM, (i == dlat) ? rd : last_rdata);
            @(negedge clk);
        end
        bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
        last_rdata = rd;

        if (!flush) begin
            for (int i = 1; i <= hold; i++) begin
                stallallM = (i < hold);
                #1;
                chk("done_stall", d_stall, 0);
                chk("done_req", bus.data_req, 0);
                chk("done_rdata", readdataM, rd);
                @(negedge clk);
            end
        end
        memenM = 1'b0; stallallM = 1'b0; flushM = 1'b0;
    endtask

    // Idle cycles: either no instruction or a flushed one, with stray data_ok pulses.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            memenM = 1'($urandom); flushM = memenM; stallallM = 1'($urandom);
            bus.data_data_ok = 1'($urandom); bus.data_rdata = $urandom;
            #1;
            chk("gap_req", bus.data_req, 0);
            chk("gap_stall", d_stall, 0);
            chk("gap_rdata", readdataM, last_rdata);
            @(negedge clk);
        end
        memenM = 1'b0; flushM = 1'b0; stallallM = 1'b0; bus.data_data_ok = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; memenM = 1'b0; memwenM = '0; membyteM = '0; addrM = '0;
        realwdataM = '0; flushM = 1'b0; stallallM = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        last_rdata = '0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_req", bus.data_req, 0);
        chk("rst_stall", d_stall, 0);
        chk("rst_rdata", readdataM, 0);
        chk("rst_wr", bus.data_wr, 0);
        chk("rst_addr", bus.data_addr, 0);
        chk("rst_wdata", bus.data_wdata, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        access(4'b0000, MEM_WORD, 32'h8000_1000, 32'h0, 32'hDEAD_BEEF, 2, 1, 0, 0);
        gap(2);
        access(4'b0100, MEM_BYTE, 32'h8000_0002, 32'h00AB_0000, 32'h1111_2222, 1, 2, 0, 0);
        gap(2);
        access(4'b0000, MEM_HALFWORD, 32'h8000_0104, 32'h0, 32'hCAFE_F00D, 1, 1, 4, 0);
        gap(1);

        memenM = 1'b1; flushM = 1'b1; #1;
        chk("flush_idle_stall", d_stall, 0);
        @(negedge clk);
        memenM = 1'b0; flushM = 1'b0; #1;
        chk("flush_idle_req", bus.data_req, 0);
        @(negedge clk);

        access(4'b1111, MEM_WORD, 32'h8000_0200, 32'h1234_5678, 32'h0BAD_CAFE, 2, 2, 3, 1);
        access(4'b0000, MEM_WORD, 32'h8000_0300, 32'h0, 32'hAAAA_0001, 1, 1, 0, 0);
        access(4'b0000, MEM_WORD, 32'h8000_0304, 32'h0, 32'hAAAA_0002, 1, 1, 0, 0);
        access(4'b0011, 2'b11, 32'h8000_0400, 32'h5555_5555, 32'h0, 1, 1, 0, 0);
        gap(1);

        for (int k = 0; k < 40; k++) begin
            logic [3:0] wen;
            wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            access(wen, 2'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0));
            gap($urandom_range(0, 2));
        end

        // Reset in the middle of a data phase.
        memenM = 1'b1; memwenM = 4'd0; membyteM = MEM_WORD; addrM = 32'h8000_0800; flushM = 1'b0;
        @(negedge clk);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0; #1;
        chk("pre_rst_stall", d_stall, 1);
        resetn = 1'b0; memenM = 1'b0; #1;
        chk("mid_rst_req", bus.data_req, 0);
        chk("mid_rst_stall", d_stall, 0);
        chk("mid_rst_rdata", readdataM, 0);
        @(negedge clk);
        resetn = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678; #1;
        chk("stray_ok_rdata", readdataM, 0);
        chk("stray_ok_req", bus.data_req, 0);
        @(negedge clk);
        bus.data_data_ok = 1'b0; #1;
        chk("after_stray_rdata", readdataM, 0);
        chk("after_stray_stall", d_stall, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
